// File: rtl/vx_tag_assoc_pkg.sv
// Shared types and helpers for the set-associative tag store.
package vx_tag_assoc_pkg;

   localparam int ADDR_WIDTH = 32;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } tag_state_e;

   // Select-field width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_tag_assoc_victim_sel.sv
// Victim picker: lowest-index invalid way, otherwise the round-robin way.
module vx_tag_assoc_victim_sel #(
   parameter int NUM_WAYS     = 4,
   parameter int WAY_SEL_BITS = 2
) (
   input  logic [NUM_WAYS-1:0]     valid_i,
   input  logic [WAY_SEL_BITS-1:0] rr_ptr_i,
   output logic [NUM_WAYS-1:0]     victim_o
);

   // Scan high to low so the lowest invalid way wins last.
   always_comb begin
      victim_o = NUM_WAYS'(1) << rr_ptr_i;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) victim_o = NUM_WAYS'(1) << w;
      end
   end

endmodule

// File: rtl/vx_tag_assoc.sv
// N-way set-associative tag store for one cache bank: storage, init/flush FSM,
// one-cycle lookup with registered hit/victim response.
module vx_tag_assoc
   import vx_tag_assoc_pkg::*;
#(
   parameter int CACHE_ID         = 0,
   parameter int BANK_ID          = 0,
   parameter int CACHE_SIZE       = 16384,
   parameter int CACHE_LINE_SIZE  = 64,
   parameter int NUM_BANKS        = 4,
   parameter int NUM_WAYS         = 4,
   parameter int WORD_SIZE        = 4,
   parameter int BANK_ADDR_OFFSET = 0,
   localparam int NUM_SETS        = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS * NUM_WAYS),
   localparam int SET_IDX_BITS    = $clog2(NUM_SETS),
   localparam int SET_SELECT_BITS = clog2_min1(NUM_SETS),
   localparam int WAY_SEL_BITS    = clog2_min1(NUM_WAYS),
   localparam int BANK_SEL_BITS   = $clog2(NUM_BANKS),
   localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(CACHE_LINE_SIZE),
   localparam int TAG_SELECT_BITS = LINE_ADDR_WIDTH - SET_IDX_BITS - BANK_SEL_BITS
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   output logic                       init_busy_o,
   output logic                       req_ready_o,
   input  logic                       lookup_i,
   input  logic                       lookup_write_i,
   input  logic [LINE_ADDR_WIDTH-1:0] addr_i,
   input  logic                       fill_i,
   input  logic [NUM_WAYS-1:0]        fill_way_i,
   input  logic                       flush_i,
   input  logic                       flush_all_i,
   output logic                       rsp_valid_o,
   output logic                       hit_o,
   output logic [NUM_WAYS-1:0]        hit_way_o,
   output logic [NUM_WAYS-1:0]        victim_way_o,
   output logic                       victim_dirty_o,
   output logic [TAG_SELECT_BITS-1:0] victim_tag_o
);

   // Reject nonsensical builds at elaboration.
   if (NUM_SETS < 1 || WORD_SIZE > CACHE_LINE_SIZE || CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_cfg
      $error("vx_tag_assoc: invalid cache geometry");
   end

   tag_state_e                 state_q, state_d;
   logic [SET_SELECT_BITS-1:0] init_idx_q, init_idx_d;

   logic [NUM_SETS-1:0][NUM_WAYS-1:0]                      valid_q, dirty_q;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_SELECT_BITS-1:0] tag_q;
   logic [NUM_SETS-1:0][WAY_SEL_BITS-1:0]                  rr_q;

   logic                       rsp_valid_q, hit_q, victim_dirty_q;
   logic [NUM_WAYS-1:0]        hit_way_q, victim_way_q;
   logic [TAG_SELECT_BITS-1:0] victim_tag_q;

   // Line address = {tag, set_hi, bank, set_lo}; set_lo is BANK_ADDR_OFFSET bits wide.
   logic [LINE_ADDR_WIDTH-1:0] addr_lo, addr_hi;
   logic [SET_SELECT_BITS-1:0] set_idx;
   logic [TAG_SELECT_BITS-1:0] line_tag;
   assign addr_lo  = addr_i & LINE_ADDR_WIDTH'((64'(1) << BANK_ADDR_OFFSET) - 64'(1));
   assign addr_hi  = (addr_i >> (BANK_ADDR_OFFSET + BANK_SEL_BITS)) << BANK_ADDR_OFFSET;
   assign set_idx  = SET_SELECT_BITS'(addr_hi | addr_lo);
   assign line_tag = TAG_SELECT_BITS'(addr_i >> (SET_IDX_BITS + BANK_SEL_BITS));

   logic ready, lookup_acc;
   assign ready       = (state_q == ST_READY);
   assign req_ready_o = ready && !flush_i && !fill_i;
   assign lookup_acc  = req_ready_o && lookup_i;
   assign init_busy_o = (state_q == ST_INIT);

   logic [NUM_WAYS-1:0]        hit_vec, victim_vec;
   logic [TAG_SELECT_BITS-1:0] victim_tag;
   logic [WAY_SEL_BITS-1:0]    rr_next;

   vx_tag_assoc_victim_sel #(
      .NUM_WAYS     (NUM_WAYS),
      .WAY_SEL_BITS (WAY_SEL_BITS)
   ) u_victim_sel (
      .valid_i  (valid_q[set_idx]),
      .rr_ptr_i (rr_q[set_idx]),
      .victim_o (victim_vec)
   );

   // Tag compare across all ways of the addressed set, plus victim tag mux.
   always_comb begin
      hit_vec    = '0;
      victim_tag = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == line_tag);
         if (victim_vec[w]) victim_tag = victim_tag | tag_q[set_idx][w];
      end
      rr_next = (NUM_WAYS == 1) ? '0 : rr_q[set_idx] + WAY_SEL_BITS'(1);
   end

   // Sweep one set per cycle in INIT; flush_all restarts the sweep from set 0.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         ST_INIT: begin
            init_idx_d = init_idx_q + SET_SELECT_BITS'(1);
            if (init_idx_q == SET_SELECT_BITS'(NUM_SETS - 1)) begin
               state_d    = ST_READY;
               init_idx_d = '0;
            end
         end
         default: begin
            if (flush_all_i) begin
               state_d    = ST_INIT;
               init_idx_d = '0;
            end
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   // Tag array updates; arrays are not reset, the INIT sweep clears them instead.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (state_q == ST_INIT) begin
            valid_q[init_idx_q] <= '0;
            dirty_q[init_idx_q] <= '0;
            rr_q[init_idx_q]    <= '0;
         end else if (flush_i) begin
            valid_q[set_idx] <= '0;
            dirty_q[set_idx] <= '0;
         end else if (fill_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (fill_way_i[w]) begin
                  valid_q[set_idx][w] <= 1'b1;
                  dirty_q[set_idx][w] <= 1'b0;
                  tag_q[set_idx][w]   <= line_tag;
               end
            end
            rr_q[set_idx] <= rr_next;
         end else if (lookup_acc && lookup_write_i) begin
            dirty_q[set_idx] <= dirty_q[set_idx] | hit_vec;
         end
      end
   end

   // Registered lookup response; rsp_valid pulses once per accepted lookup.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rsp_valid_q    <= 1'b0;
         hit_q          <= 1'b0;
         hit_way_q      <= '0;
         victim_way_q   <= '0;
         victim_dirty_q <= 1'b0;
         victim_tag_q   <= '0;
      end else begin
         rsp_valid_q <= lookup_acc;
         if (lookup_acc) begin
            hit_q          <= |hit_vec;
            hit_way_q      <= hit_vec;
            victim_way_q   <= victim_vec;
            victim_dirty_q <= |(victim_vec & valid_q[set_idx] & dirty_q[set_idx]);
            victim_tag_q   <= victim_tag;
         end
      end
   end

   assign rsp_valid_o    = rsp_valid_q;
   assign hit_o          = hit_q;
   assign hit_way_o      = hit_way_q;
   assign victim_way_o   = victim_way_q;
   assign victim_dirty_o = victim_dirty_q;
   assign victim_tag_o   = victim_tag_q;

`ifndef SYNTHESIS
   // A fill must name exactly one way.
   always_ff @(posedge clk_i) begin
      if (!reset_i && ready && fill_i && !flush_i)
         assert ($onehot(fill_way_i)) else $error("vx_tag_assoc: fill_way not one-hot");
   end
`endif

endmodule

// File: tb/tb_vx_tag_assoc.sv
// Bench for vx_tag_assoc: vector table + response scoreboard, with hand-written
// init/flush_all/mid-sweep-reset sequences and a direct-mapped (NUM_WAYS=1) instance.
module tb_vx_tag_assoc;

   localparam int OP_NOP = 0, OP_LD = 1, OP_ST = 2, OP_FILL = 3,
                  OP_FLUSH = 4, OP_FILL_LD = 5, OP_FLUSH_LD = 6;

   logic        clk = 1'b0, reset = 1'b1;
   logic        init_busy, req_ready, lookup, lookup_write, fill, flush, flush_all;
   logic [25:0] addr;
   logic [3:0]  fill_way, hit_way, victim_way;
   logic        rsp_valid, hit, victim_dirty;
   logic [19:0] victim_tag;

   logic        w1_init_busy, w1_req_ready, w1_lookup, w1_lookup_write, w1_fill, w1_flush, w1_flush_all;
   logic [25:0] w1_addr;
   logic [0:0]  w1_fill_way, w1_hit_way, w1_victim_way;
   logic        w1_rsp_valid, w1_hit, w1_victim_dirty;
   logic [17:0] w1_victim_tag;

   always #5 clk = ~clk;

   vx_tag_assoc dut (
      .clk_i(clk), .reset_i(reset), .init_busy_o(init_busy), .req_ready_o(req_ready),
      .lookup_i(lookup), .lookup_write_i(lookup_write), .addr_i(addr), .fill_i(fill),
      .fill_way_i(fill_way), .flush_i(flush), .flush_all_i(flush_all), .rsp_valid_o(rsp_valid),
      .hit_o(hit), .hit_way_o(hit_way), .victim_way_o(victim_way),
      .victim_dirty_o(victim_dirty), .victim_tag_o(victim_tag));

   vx_tag_assoc #(.NUM_WAYS(1)) dut_w1 (
      .clk_i(clk), .reset_i(reset), .init_busy_o(w1_init_busy), .req_ready_o(w1_req_ready),
      .lookup_i(w1_lookup), .lookup_write_i(w1_lookup_write), .addr_i(w1_addr), .fill_i(w1_fill),
      .fill_way_i(w1_fill_way), .flush_i(w1_flush), .flush_all_i(w1_flush_all),
      .rsp_valid_o(w1_rsp_valid), .hit_o(w1_hit), .hit_way_o(w1_hit_way),
      .victim_way_o(w1_victim_way), .victim_dirty_o(w1_victim_dirty), .victim_tag_o(w1_victim_tag));

   typedef struct {
      int         op;
      logic [19:0] tag;
      logic [3:0] set;
      logic [3:0] way;
      logic       rdy;
      logic       hit;
      logic [3:0] hw;
      logic       cv;
      logic [3:0] vw;
      logic       vd;
      logic       ct;
      logic [19:0] vt;
   } vec_t;

   typedef struct {
      int          id;
      logic        hit;
      logic [3:0]  hw;
      logic        cv;
      logic [3:0]  vw;
      logic        vd;
      logic        ct;
      logic [19:0] vt;
   } exp_t;

   exp_t sbq[$];
   vec_t tv[$];
   int   nvec = 0, nerr = 0;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s #%0d: got %0h, expected %0h", nm, id, act, exp);
      end
   endtask

   function automatic vec_t mk(int op, int tag, int set, int way, int rdy, int h, int hw,
                               int cv, int vw, int vd, int ct, int vt);
      vec_t v;
      v.op = op;   v.tag = 20'(tag); v.set = 4'(set); v.way = 4'(way);
      v.rdy = rdy[0]; v.hit = h[0]; v.hw = 4'(hw); v.cv = cv[0];
      v.vw = 4'(vw); v.vd = vd[0]; v.ct = ct[0]; v.vt = 20'(vt);
      return v;
   endfunction

   task automatic idle();
      lookup = 0; lookup_write = 0; fill = 0; flush = 0; flush_all = 0; fill_way = '0;
   endtask

   task automatic apply(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      lookup       = v.op inside {OP_LD, OP_ST, OP_FILL_LD, OP_FLUSH_LD};
      lookup_write = (v.op == OP_ST);
      fill         = v.op inside {OP_FILL, OP_FILL_LD};
      flush        = v.op inside {OP_FLUSH, OP_FLUSH_LD};
      flush_all    = 1'b0;
      fill_way     = v.way;
      addr         = {v.tag, v.set, 2'b00};
      #1 chk("req_ready", id, 32'(req_ready), 32'(v.rdy));
      if (lookup && v.rdy) begin
         e.id = id; e.hit = v.hit; e.hw = v.hw; e.cv = v.cv; e.vw = v.vw;
         e.vd = v.vd; e.ct = v.ct; e.vt = v.vt;
         sbq.push_back(e);
      end
   endtask

   // Count cycles of init_busy starting now (just after a negedge), bounded.
   task automatic count_busy(input string nm, input int exp_n);
      int n = 0;
      while (init_busy && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      chk(nm, 0, 32'(n), 32'(exp_n));
   endtask

   // Response monitor: every queued expectation must be answered on the next edge.
   always @(posedge clk) begin : mon
      exp_t e;
      #2;
      if (rsp_valid) begin
         if (sbq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_rsp: rsp_valid=1, expected no response");
         end else begin
            e = sbq.pop_front();
            chk("hit", e.id, 32'(hit), 32'(e.hit));
            chk("hit_way", e.id, 32'(hit_way), 32'(e.hw));
            if (e.cv) begin
               chk("victim_way", e.id, 32'(victim_way), 32'(e.vw));
               chk("victim_dirty", e.id, 32'(victim_dirty), 32'(e.vd));
            end
            if (e.ct) chk("victim_tag", e.id, 32'(victim_tag), 32'(e.vt));
         end
      end else if (sbq.size() != 0) begin
         e = sbq.pop_front();
         nvec++; nerr++;
         $display("FAIL missing_rsp #%0d: rsp_valid=0, expected 1", e.id);
      end
   end

   initial begin
      int n;
      idle(); addr = '0;
      w1_lookup = 0; w1_lookup_write = 0; w1_fill = 0; w1_flush = 0; w1_flush_all = 0;
      w1_fill_way = '0; w1_addr = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_init_busy", 0, 32'(init_busy), 1);
      chk("rst_req_ready", 0, 32'(req_ready), 0);
      chk("rst_rsp", 0, {rsp_valid, hit, victim_dirty}, 0);
      chk("rst_ways", 0, {hit_way, victim_way}, 0);
      chk("rst_victim_tag", 0, 32'(victim_tag), 0);
      @(negedge clk); reset = 1'b0; #1;
      count_busy("init_cycles", 16);

      // set 0: tags 1..4 filled into ways 0..3 (addr for tag 4 set 0 is 0x100)
      tv.push_back(mk(OP_LD,       4, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     3, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     4, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       3, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       5, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1));
      tv.push_back(mk(OP_ST,       2, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       2, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       6, 0, 0, 1, 0, 0, 1, 2, 1, 1, 2));
      tv.push_back(mk(OP_FILL_LD,  6, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       6, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       7, 0, 0, 1, 0, 0, 1, 4, 0, 1, 3));
      tv.push_back(mk(OP_FILL,     7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     7, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_ST,       7, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_ST,       7, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       7, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       3, 1, 0, 1, 0, 0, 1, 2, 0, 0, 0));
      tv.push_back(mk(OP_FLUSH,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FLUSH_LD, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_LD,       3, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      tv.push_back(mk(OP_NOP,      0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_FILL,     9, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(OP_ST,       9, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0));
      foreach (tv[i]) apply(tv[i], i);

      // flush_all with four sets populated (some dirty)
      @(negedge clk); idle(); flush_all = 1'b1;
      @(negedge clk); flush_all = 1'b0; #1;
      count_busy("flush_all_cycles", 16);
      tv.delete();
      tv.push_back(mk(OP_LD, 9, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      tv.push_back(mk(OP_LD, 7, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      tv.push_back(mk(OP_LD, 7, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      tv.push_back(mk(OP_LD, 7, 3, 0, 1, 0, 0, 1, 1, 0, 0, 0));
      foreach (tv[i]) apply(tv[i], 100 + i);
      @(negedge clk); idle();

      // Reset asserted at sweep index 7: sweep must restart from set 0
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      count_busy("midsweep_reset_cycles", 16);

      // Direct-mapped build
      n = 0;
      while (w1_init_busy && n < 200) begin n++; @(negedge clk); end
      chk("w1_init_done", 0, 32'(w1_init_busy), 0);
      @(negedge clk);
      w1_addr = {18'd3, 6'd5, 2'b00}; w1_lookup = 1'b1;
      #1 chk("w1_req_ready", 0, 32'(w1_req_ready), 1);
      @(negedge clk); w1_lookup = 1'b0;
      chk("w1_miss", 0, {w1_rsp_valid, w1_hit, w1_victim_way}, 3'b101);
      w1_fill = 1'b1; w1_fill_way = 1'b1;
      @(negedge clk); w1_fill = 1'b0; w1_fill_way = 1'b0; w1_lookup = 1'b1; w1_lookup_write = 1'b1;
      @(negedge clk); w1_lookup = 1'b0; w1_lookup_write = 1'b0;
      chk("w1_hit", 0, {w1_rsp_valid, w1_hit, w1_hit_way}, 3'b111);
      w1_addr = {18'd4, 6'd5, 2'b00}; w1_lookup = 1'b1;
      @(negedge clk); w1_lookup = 1'b0;
      chk("w1_victim", 0, {w1_rsp_valid, w1_hit, w1_victim_way, w1_victim_dirty}, 4'b1011);
      chk("w1_victim_tag", 0, 32'(w1_victim_tag), 3);

      repeat (2) @(negedge clk);
      chk("sb_drain", 0, 32'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
